// File: rtl/triloc_minmax_seq.sv
// triloc_minmax_seq: streamed K-anchor position estimate (min-max box or centroid sums)
module triloc_minmax_seq #(
  parameter int N = 8,
  parameter int K = 3,
  localparam int OW = N + 4 + $clog2(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x_in,
  input  logic [N-1:0]  y_in,
  input  logic [N:0]    r_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] x_out,
  output logic [OW-1:0] y_out,
  output logic          empty,
  output logic          busy
);
  localparam int W = N + 3;
  localparam int CW = $clog2(K);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic mode, acc, last, first;
  logic signed [W-1:0] xs, ys, rz, xl, xh, yl, yh;
  logic signed [W-1:0] xlo, xhi, ylo, yhi, xlo_n, xhi_n, ylo_n, yhi_n;
  logic signed [OW-1:0] sx, sy, sx_n, sy_n, mm_x, mm_y;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign acc = in_valid & in_ready;
  assign first = cnt == '0;
  assign last = acc && cnt == CW'(K - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start ? ACCUM : IDLE) :
               state == ACCUM ? (last ? DONE : ACCUM) :
               (out_ready ? IDLE : DONE);
  end
  // box bounds of the current beat; the first beat seeds the intersection
  assign xs = {{3{x_in[N-1]}}, x_in};
  assign ys = {{3{y_in[N-1]}}, y_in};
  assign rz = {2'b00, r_in};
  assign xl = xs - rz;
  assign xh = xs + rz;
  assign yl = ys - rz;
  assign yh = ys + rz;
  assign xlo_n = (first || xl > xlo) ? xl : xlo;
  assign xhi_n = (first || xh < xhi) ? xh : xhi;
  assign ylo_n = (first || yl > ylo) ? yl : ylo;
  assign yhi_n = (first || yh < yhi) ? yh : yhi;
  assign sx_n = sx + {{(OW-W){xs[W-1]}}, xs};
  assign sy_n = sy + {{(OW-W){ys[W-1]}}, ys};
  assign mm_x = {{(OW-W){xlo_n[W-1]}}, xlo_n} + {{(OW-W){xhi_n[W-1]}}, xhi_n};
  assign mm_y = {{(OW-W){ylo_n[W-1]}}, ylo_n} + {{(OW-W){yhi_n[W-1]}}, yhi_n};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      mode <= 1'b0;
      xlo <= '0;
      xhi <= '0;
      ylo <= '0;
      yhi <= '0;
      sx <= '0;
      sy <= '0;
      x_out <= '0;
      y_out <= '0;
      empty <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= '0;
        mode <= mode_in;
        sx <= '0;
        sy <= '0;
      end
      if (acc) begin
        cnt <= cnt + 1'b1;
        xlo <= xlo_n;
        xhi <= xhi_n;
        ylo <= ylo_n;
        yhi <= yhi_n;
        sx <= sx_n;
        sy <= sy_n;
        if (last) begin
          x_out <= mode ? sx_n : mm_x;
          y_out <= mode ? sy_n : mm_y;
          empty <= !mode && (xlo_n > xhi_n || ylo_n > yhi_n);
        end
      end
    end
endmodule

// File: tb/tb_triloc_minmax_seq.sv
// tb_triloc_minmax_seq: directed spec vectors plus random anchors checked against a box/centroid model
module tb_triloc_minmax_seq;
  localparam int N = 8;
  localparam int K = 3;
  localparam int OW = N + 4 + $clog2(K);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode_in = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, empty, busy;
  logic [N-1:0] x_in = '0, y_in = '0;
  logic [N:0] r_in = '0;
  logic [OW-1:0] x_out, y_out;
  int total = 0, bad = 0;
  int ax[K], ay[K], ar[K];

  triloc_minmax_seq #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .in_valid(in_valid),
    .in_ready(in_ready), .x_in(x_in), .y_in(y_in), .r_in(r_in), .out_valid(out_valid),
    .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int sx_out();
    return int'($signed(x_out));
  endfunction
  function automatic int sy_out();
    return int'($signed(y_out));
  endfunction

  // Intersection of all boxes taken at once, or plain coordinate sums
  function automatic void model(input bit m, output int ex, output int ey, output int ee);
    int xlo, xhi, ylo, yhi;
    ex = 0; ey = 0; ee = 0;
    xlo = -100000; xhi = 100000; ylo = -100000; yhi = 100000;
    for (int i = 0; i < K; i++) begin
      ex += ax[i];
      ey += ay[i];
      if (ax[i] - ar[i] > xlo) xlo = ax[i] - ar[i];
      if (ax[i] + ar[i] < xhi) xhi = ax[i] + ar[i];
      if (ay[i] - ar[i] > ylo) ylo = ay[i] - ar[i];
      if (ay[i] + ar[i] < yhi) yhi = ay[i] + ar[i];
    end
    if (!m) begin
      ex = xlo + xhi;
      ey = ylo + yhi;
      ee = (xlo > xhi || ylo > yhi) ? 1 : 0;
    end
  endfunction

  function automatic void set3(input int a0, b0, c0, a1, b1, c1, a2, b2, c2);
    ax[0] = a0; ay[0] = b0; ar[0] = c0;
    ax[1] = a1; ay[1] = b1; ar[1] = c1;
    ax[2] = a2; ay[2] = b2; ar[2] = c2;
  endfunction

  // Called at a negedge; leaves the DUT in ACCUM at the next negedge
  task automatic start_est(input bit m);
    start = 1'b1;
    mode_in = m;
    @(negedge clk);
    start = 1'b0;
    mode_in = ~m;
  endtask

  task automatic feed(input int nb, input int gap_pct, input bit pulse);
    int i = 0, cyc = 0;
    while (i < nb && cyc < 500) begin
      in_valid = $urandom_range(99) >= gap_pct;
      x_in = N'(ax[i]); y_in = N'(ay[i]); r_in = (N+1)'(ar[i]);
      start = pulse & $urandom_range(1);
      mode_in = $urandom_range(1);
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (cyc >= 500) begin
      total++; bad++;
      $display("FAIL feed_timeout: accepted %0d beats, required %0d", i, nb);
    end
  endtask

  task automatic run_est(input string name, input bit m, input int gap_pct, input bit pulse,
                         input int hold, input int ex, input int ey, input int ee);
    logic [OW-1:0] hx, hy;
    logic he;
    start_est(m);
    feed(K, gap_pct, pulse);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid: got %b want 1", name, out_valid); end
    total++;
    if (sx_out() !== ex) begin bad++; $display("FAIL %s x_out: got %0d want %0d", name, sx_out(), ex); end
    total++;
    if (sy_out() !== ey) begin bad++; $display("FAIL %s y_out: got %0d want %0d", name, sy_out(), ey); end
    total++;
    if (int'(empty) !== ee) begin bad++; $display("FAIL %s empty: got %b want %0d", name, empty, ee); end
    hx = x_out; hy = y_out; he = empty;
    for (int c = 0; c < hold; c++) begin
      out_ready = 1'b0;
      start = pulse & $urandom_range(1);
      mode_in = $urandom_range(1);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || x_out !== hx || y_out !== hy || empty !== he) begin
        bad++;
        $display("FAIL %s hold[%0d]: got v=%b x=%0d y=%0d e=%b want v=1 x=%0d y=%0d e=%b",
                 name, c, out_valid, sx_out(), sy_out(), empty, int'($signed(hx)), int'($signed(hy)), he);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s release: got v=%b busy=%b want 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || empty !== 1'b0 || x_out !== '0 || y_out !== '0) begin
      bad++; $display("FAIL reset: got rdy=%b v=%b busy=%b e=%b x=%0d y=%0d want all 0",
                      in_ready, out_valid, busy, empty, sx_out(), sy_out());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_vectors;
    set3(-16, -111, 236, 109, -99, 183, -32, 108, 215);
    run_est("mm_basic", 1'b0, 0, 1'b0, 0, 109, -23, 0);
    run_est("centroid", 1'b1, 0, 1'b0, 0, 61, -102, 0);
    set3(0, 0, 1, 100, 0, 1, 0, 100, 1);
    run_est("mm_empty", 1'b0, 0, 1'b0, 1, 100, 100, 1);
    set3(127, -128, 511, 127, -128, 511, 127, -128, 511);
    run_est("mm_ext_r", 1'b0, 0, 1'b0, 0, 254, -256, 0);
    set3(-128, -128, 0, -128, -128, 0, -128, -128, 0);
    run_est("mm_degen", 1'b0, 0, 1'b0, 0, -256, -256, 0);
  endtask

  task automatic test_flow;
    set3(-16, -111, 236, 109, -99, 183, -32, 108, 215);
    run_est("flow_gaps", 1'b0, 50, 1'b1, 5, 109, -23, 0);
    run_est("back_to_back", 1'b0, 0, 1'b1, 2, 109, -23, 0);
    run_est("flow_cent", 1'b1, 40, 1'b1, 3, 61, -102, 0);
  endtask

  task automatic test_random;
    int ex, ey, ee;
    bit m;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < K; i++) begin
        ax[i] = int'($urandom_range(255)) - 128;
        ay[i] = int'($urandom_range(255)) - 128;
        ar[i] = $urandom_range(511);
      end
      m = $urandom_range(1);
      model(m, ex, ey, ee);
      run_est("random", m, 30, 1'b1, $urandom_range(3), ex, ey, ee);
    end
  endtask

  task automatic test_reset_mid;
    set3(-16, -111, 236, 109, -99, 183, -32, 108, 215);
    start_est(1'b0);
    feed(2, 0, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || x_out !== '0 || y_out !== '0) begin
      bad++; $display("FAIL rst_mid_during: got busy=%b rdy=%b v=%b x=%0d y=%0d want all 0",
                      busy, in_ready, out_valid, sx_out(), sy_out());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || x_out !== '0 || y_out !== '0 || empty !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: got busy=%b x=%0d y=%0d e=%b want 0 0 0 0",
                      busy, sx_out(), sy_out(), empty);
    end
    run_est("after_rst", 1'b1, 0, 1'b0, 0, 61, -102, 0);
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_flow;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
